// File: rtl/stage_waveform_generation.sv
// stage_waveform_generation
// Quarter-wave sine lookup stage sitting directly after phase accumulation.
// Converts a 17-bit modulated phase (one period = 2^16) into a signed 16-bit
// sample. The slot identity (VoiceOperator, AlgorithmWord) travels alongside
// the sample so downstream envelope/mixing stages stay aligned.
//
// Optional feature macro: WAVEFORM_INTERPOLATION_EN
//   undefined : m = T[i], latency 3 (input edge -> output edge)
//   defined   : linear interpolation between T[i] and T[i+1] using the four
//               fractional phase bits, extra multiply stage, latency 4
//
// Pipeline (default build):
//   C1  phase folding: register quadrant sign, table index, valid, sidebands
//   C2  synchronous ROM read
//   C3  apply sign, register outputs
`timescale 1ns/1ps

typedef logic [5:0]  VoiceOperatorID_t;
typedef logic [15:0] AlgorithmWord_t;

module stage_waveform_generation (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Valid,
  input  logic signed [16:0]  i_ModulatedPhase,
  input  VoiceOperatorID_t    i_VoiceOperator,
  input  AlgorithmWord_t      i_AlgorithmWord,
  output logic                o_Valid,
  output logic signed [15:0]  o_Sample,
  output VoiceOperatorID_t    o_VoiceOperator,
  output AlgorithmWord_t      o_AlgorithmWord
);

  localparam int  TABLE_DEPTH = 1024;
  localparam int  TABLE_WIDTH = 15;
  localparam int  INDEX_WIDTH = 10;
  localparam real TWO_PI      = 6.283185307179586;
  localparam logic [TABLE_WIDTH-1:0] FULL_SCALE = 15'd32767;

  // Quarter-wave entry: round(32767 * sin(2*pi*(idx+0.5)/4096)).
  // The half-step offset makes T[i] of the rising quarter equal T[1023-i] of
  // the falling quarter, so mirroring is a plain bit inversion.
  function automatic logic [TABLE_WIDTH-1:0] sine_entry(input int idx);
    real angle;
    real scaled;
    angle  = TWO_PI * (real'(idx) + 0.5) / 4096.0;
    scaled = 32767.0 * $sin(angle) + 0.5;
    return TABLE_WIDTH'($rtoi(scaled));
  endfunction

  // ---------------------------------------------------------------------------
  // Sine ROM, contents fixed at elaboration; read through registers only.
  // ---------------------------------------------------------------------------
  logic [TABLE_WIDTH-1:0] sine_rom [TABLE_DEPTH];

  generate
    for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_sine_rom
      assign sine_rom[gi] = sine_entry(gi);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Phase folding (combinational front of C1)
  // Bit 16 is dropped: phases alias modulo 2^16. Quadrants 1 and 3 walk the
  // table backwards, quadrants 2 and 3 produce negative samples.
  // ---------------------------------------------------------------------------
  logic [15:0] phase_wrapped;
  logic [1:0]  quadrant;
  logic [13:0] local_phase;
  logic        unused_phase_msb;

  assign phase_wrapped    = i_ModulatedPhase[15:0];
  assign unused_phase_msb = i_ModulatedPhase[16];
  assign quadrant         = phase_wrapped[15:14];
  assign local_phase      = quadrant[0] ? ~phase_wrapped[13:0] : phase_wrapped[13:0];

  // ---------------------------------------------------------------------------
  // C1 registers
  // ---------------------------------------------------------------------------
  logic                   s1_valid_reg;
  logic                   s1_negate_reg;
  logic [INDEX_WIDTH-1:0] s1_index_reg;
  VoiceOperatorID_t       s1_voice_reg;
  AlgorithmWord_t         s1_algo_reg;
`ifdef WAVEFORM_INTERPOLATION_EN
  logic [3:0]             s1_frac_reg;
`else
  logic [3:0]             unused_frac;
  assign unused_frac = local_phase[3:0];
`endif

  // C1 valid bit: cleared by reset, and a slot presented during reset is lost
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= i_Valid;
    end
  end

  // C1 data path: folded phase and sidebands, free-running regardless of valid
  always_ff @(posedge i_Clock) begin
    s1_negate_reg <= quadrant[1];
    s1_index_reg  <= local_phase[13:4];
    s1_voice_reg  <= i_VoiceOperator;
    s1_algo_reg   <= i_AlgorithmWord;
`ifdef WAVEFORM_INTERPOLATION_EN
    s1_frac_reg   <= local_phase[3:0];
`endif
  end

  // ---------------------------------------------------------------------------
  // C2: ROM read
  // ---------------------------------------------------------------------------
  logic                   s2_valid_reg;
  logic                   s2_negate_reg;
  logic [TABLE_WIDTH-1:0] rom_data_reg;
  VoiceOperatorID_t       s2_voice_reg;
  AlgorithmWord_t         s2_algo_reg;
`ifdef WAVEFORM_INTERPOLATION_EN
  logic [TABLE_WIDTH-1:0] rom_next_reg;
  logic                   s2_clamp_reg;
  logic [3:0]             s2_frac_reg;
  logic [INDEX_WIDTH-1:0] next_index;

  // The neighbour index wraps to 0 at the top of the table; that read is
  // replaced by full scale in C3, so the wrapped value is never used.
  assign next_index = s1_index_reg + 10'd1;
`endif

  // C2 valid bit: dropped on reset so in-flight slots never complete
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s2_valid_reg <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // C2 data path: registered table read(s) plus sideband delay
  always_ff @(posedge i_Clock) begin
    rom_data_reg  <= sine_rom[s1_index_reg];
    s2_negate_reg <= s1_negate_reg;
    s2_voice_reg  <= s1_voice_reg;
    s2_algo_reg   <= s1_algo_reg;
`ifdef WAVEFORM_INTERPOLATION_EN
    rom_next_reg  <= sine_rom[next_index];
    s2_clamp_reg  <= (s1_index_reg == 10'd1023);
    s2_frac_reg   <= s1_frac_reg;
`endif
  end

  // ---------------------------------------------------------------------------
  // Final-stage operands (C3 interpolation only when enabled)
  // ---------------------------------------------------------------------------
  logic                   final_valid;
  logic                   final_negate;
  logic [TABLE_WIDTH-1:0] final_magnitude;
  VoiceOperatorID_t       final_voice;
  AlgorithmWord_t         final_algo;

`ifdef WAVEFORM_INTERPOLATION_EN
  logic                   s3_valid_reg;
  logic                   s3_negate_reg;
  logic [TABLE_WIDTH-1:0] s3_magnitude_reg;
  VoiceOperatorID_t       s3_voice_reg;
  AlgorithmWord_t         s3_algo_reg;

  logic [TABLE_WIDTH-1:0] next_entry;
  logic [TABLE_WIDTH-1:0] step_delta;
  logic [TABLE_WIDTH+3:0] step_product;
  logic [TABLE_WIDTH-1:0] step_scaled;
  logic [TABLE_WIDTH-1:0] magnitude_next;

  // Beyond the last entry the curve is flat at full scale. The table is
  // monotonic within a quarter, so the delta is never negative (max ~50).
  assign next_entry     = s2_clamp_reg ? FULL_SCALE : rom_next_reg;
  assign step_delta     = next_entry - rom_data_reg;
  assign step_product   = {4'b0000, step_delta} * {15'd0, s2_frac_reg};
  assign step_scaled    = TABLE_WIDTH'(step_product >> 4);
  assign magnitude_next = rom_data_reg + step_scaled;

  // C3 valid bit: cleared by reset alongside the earlier stages
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s3_valid_reg <= 1'b0;
    end else begin
      s3_valid_reg <= s2_valid_reg;
    end
  end

  // C3 data path: interpolated magnitude and sideband delay
  always_ff @(posedge i_Clock) begin
    s3_magnitude_reg <= magnitude_next;
    s3_negate_reg    <= s2_negate_reg;
    s3_voice_reg     <= s2_voice_reg;
    s3_algo_reg      <= s2_algo_reg;
  end

  assign final_valid     = s3_valid_reg;
  assign final_negate    = s3_negate_reg;
  assign final_magnitude = s3_magnitude_reg;
  assign final_voice     = s3_voice_reg;
  assign final_algo      = s3_algo_reg;
`else
  assign final_valid     = s2_valid_reg;
  assign final_negate    = s2_negate_reg;
  assign final_magnitude = rom_data_reg;
  assign final_voice     = s2_voice_reg;
  assign final_algo      = s2_algo_reg;
`endif

  // ---------------------------------------------------------------------------
  // Output stage: sign application. The magnitude is zero-extended before
  // negation, so -32767 is the most negative value and nothing overflows.
  // ---------------------------------------------------------------------------
  logic [15:0] magnitude_ext;
  logic [15:0] sample_next;

  assign magnitude_ext = {1'b0, final_magnitude};
  assign sample_next   = final_negate ? (16'd0 - magnitude_ext) : magnitude_ext;

  // Output registers: all cleared on reset, otherwise loaded every cycle
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Valid         <= 1'b0;
      o_Sample        <= '0;
      o_VoiceOperator <= '0;
      o_AlgorithmWord <= '0;
    end else begin
      o_Valid         <= final_valid;
      o_Sample        <= $signed(sample_next);
      o_VoiceOperator <= final_voice;
      o_AlgorithmWord <= final_algo;
    end
  end

endmodule

// File: tb/tb_stage_waveform_generation.sv
// tb_stage_waveform_generation
// Scoreboard bench for stage_waveform_generation. The driver pushes the
// expected sample, sidebands and arrival cycle for each live slot; a monitor
// pops and compares whenever o_Valid is high. Honours WAVEFORM_INTERPOLATION_EN.
`timescale 1ns/1ps

module tb_stage_waveform_generation;

`ifdef WAVEFORM_INTERPOLATION_EN
  localparam int LATENCY = 4;
  localparam int EXP_PHASE8 = 50;  // 25 + ((75 - 25) * 8 >> 4)
`else
  localparam int LATENCY = 3;
  localparam int EXP_PHASE8 = 25;  // frac bits ignored, T[0]
`endif

  logic               i_Clock = 1'b0;
  logic               i_Reset = 1'b1;
  logic               i_Valid = 1'b1;
  logic signed [16:0] i_ModulatedPhase = '0;
  logic [5:0]         i_VoiceOperator = '0;
  logic [15:0]        i_AlgorithmWord = '0;
  logic               o_Valid;
  logic signed [15:0] o_Sample;
  logic [5:0]         o_VoiceOperator;
  logic [15:0]        o_AlgorithmWord;

  stage_waveform_generation dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_Valid          (i_Valid),
    .i_ModulatedPhase (i_ModulatedPhase),
    .i_VoiceOperator  (i_VoiceOperator),
    .i_AlgorithmWord  (i_AlgorithmWord),
    .o_Valid          (o_Valid),
    .o_Sample         (o_Sample),
    .o_VoiceOperator  (o_VoiceOperator),
    .o_AlgorithmWord  (o_AlgorithmWord)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic signed [15:0] sample;
    logic [5:0]         voice;
    logic [15:0]        algo;
    int                 due;
    string              name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t mon_e;

  // Edge counter used to time-stamp expectations
  always @(posedge i_Clock) cyc <= cyc + 1;

  // Ideal table entry; index 1024 is the clamped full-scale neighbour
  function automatic int table_entry(input int idx);
    if (idx >= 1024) return 32767;
    return $rtoi(32767.0 * $sin(6.283185307179586 * (real'(idx) + 0.5) / 4096.0) + 0.5);
  endfunction

  // Reference sample for an arbitrary phase
  function automatic int ref_sample(input logic [16:0] phase);
    logic [15:0] p;
    logic [13:0] l;
    int          idx;
    int          frac;
    int          m;
    p    = phase[15:0];
    l    = p[14] ? ~p[13:0] : p[13:0];
    idx  = int'(l[13:4]);
    frac = int'(l[3:0]);
    m    = table_entry(idx);
`ifdef WAVEFORM_INTERPOLATION_EN
    m = m + (((table_entry(idx + 1) - m) * frac) >>> 4);
`else
    if (frac > 15) m = 0;
`endif
    return p[15] ? -m : m;
  endfunction

  // Present one live slot and record its expected output
  task automatic send(input logic [16:0] phase, input logic [5:0] voice,
                      input logic [15:0] algo, input int expected, input string name);
    exp_t e;
    i_Valid          = 1'b1;
    i_ModulatedPhase = phase;
    i_VoiceOperator  = voice;
    i_AlgorithmWord  = algo;
    e.sample = 16'(expected);
    e.voice  = voice;
    e.algo   = algo;
    e.due    = cyc + LATENCY;
    e.name   = name;
    exp_q.push_back(e);
    @(posedge i_Clock); #1;
  endtask

  // Present a dead slot with junk data
  task automatic idle();
    i_Valid          = 1'b0;
    i_ModulatedPhase = 17'($urandom);
    i_VoiceOperator  = 6'($urandom);
    i_AlgorithmWord  = 16'($urandom);
    @(posedge i_Clock); #1;
  endtask

  // All outputs must read zero while/after reset
  task automatic check_zero(input string name);
    checks++;
    if (o_Valid !== 1'b0 || o_Sample !== 16'sd0 || o_VoiceOperator !== 6'd0 || o_AlgorithmWord !== 16'd0) begin
      errors++;
      $display("FAIL %s: got valid=%b sample=%0d voice=%0d algo=%h, required all zero",
               name, o_Valid, o_Sample, o_VoiceOperator, o_AlgorithmWord);
    end
  endtask

  // Hold reset with live input; slots in flight past this cycle are dropped
  task automatic reset_for(input int n, input string name);
    exp_t kept[$];
    kept = {};
    foreach (exp_q[k]) if (exp_q[k].due <= cyc) kept.push_back(exp_q[k]);
    exp_q = kept;
    i_Reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      i_Valid          = 1'b1;
      i_ModulatedPhase = 17'($urandom);
      i_VoiceOperator  = 6'($urandom);
      i_AlgorithmWord  = 16'($urandom);
      @(posedge i_Clock); #1;
      check_zero(name);
    end
    i_Reset = 1'b0;
    i_Valid = 1'b0;
  endtask

  // Monitor: pop and compare on every live output
  always @(negedge i_Clock) begin
    if (o_Valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sample=%0d voice=%0d at cycle %0d, required no output",
                 o_Sample, o_VoiceOperator, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_Sample !== mon_e.sample || o_VoiceOperator !== mon_e.voice ||
            o_AlgorithmWord !== mon_e.algo || cyc != mon_e.due) begin
          errors++;
          $display("FAIL %s: got sample=%0d voice=%0d algo=%h cycle=%0d, required sample=%0d voice=%0d algo=%h cycle=%0d",
                   mon_e.name, o_Sample, o_VoiceOperator, o_AlgorithmWord, cyc,
                   mon_e.sample, mon_e.voice, mon_e.algo, mon_e.due);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200us;
    $display("FAIL watchdog: got no completion, required finish within 200us");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [16:0] ph;
    @(posedge i_Clock); #1;
    reset_for(3, "reset_hold");

    // Quadrant, wrap and boundary points with hand-computed results
    send(17'h00000, 6'd1,  16'hA001, 25,         "phase_0x00000");
    send(17'h03FF0, 6'd2,  16'hA002, 32767,      "phase_0x03FF0");
    send(17'h04000, 6'd3,  16'hA003, 32767,      "phase_0x04000");
    send(17'h08000, 6'd4,  16'hA004, -25,        "phase_0x08000");
    send(17'h0C000, 6'd5,  16'hA005, -32767,     "phase_0x0C000");
    send(17'h10000, 6'd6,  16'hA006, 25,         "wrap_0x10000");
    send(17'h1C000, 6'd7,  16'hA007, -32767,     "wrap_0x1C000");
    send(17'h00008, 6'd8,  16'hA008, EXP_PHASE8, "phase_0x00008");
    send(17'h07FFF, 6'd9,  16'hA009, 25,         "mirror_0x07FFF");
    send(17'h03FFF, 6'd10, 16'hA00A, 32767,      "clamp_0x03FFF");

    // 64 back-to-back slots, ascending voice id, random phases
    for (int k = 0; k < 64; k++) begin
      ph = 17'($urandom);
      send(ph, 6'(k), 16'($urandom), ref_sample(ph), "burst");
    end

    // Alternating valid pattern
    for (int k = 0; k < 4; k++) begin
      ph = 17'($urandom);
      send(ph, 6'(k + 20), 16'($urandom), ref_sample(ph), "alternate");
      idle();
    end

    // Two slots in flight, then a one-cycle reset pulse drops them
    send(17'h04000, 6'd40, 16'hB001, 32767, "inflight_a");
    send(17'h0C000, 6'd41, 16'hB002, -32767, "inflight_b");
    reset_for(1, "reset_pulse");

    // Recovery after the pulse
    for (int k = 0; k < 4; k++) begin
      ph = 17'($urandom);
      send(ph, 6'(k + 50), 16'($urandom), ref_sample(ph), "recover");
    end

    repeat (LATENCY + 3) idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs still pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
